// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-writable word memory that spends WAIT_CYCLES extra cycles per access.
// stallreq is high while an access is outstanding; rdata is registered and holds until the next read.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        addr_err
);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  stall_nxt;
  logic                  accept;
  logic                  perform;
  logic [3:0]            lat_wen;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            acc_wen;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_word;
  logic                  acc_in_range;
  logic                  unused_addr_lsbs;
  logic [31:0]           mem [DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_nxt = stallreq;
    accept    = 1'b0;
    perform   = 1'b0;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            perform = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = WAIT_INIT;
            stall_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        // Inputs are deliberately ignored here: the stalled pipeline keeps re-presenting requests.
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          perform   = 1'b1;
          state_nxt = IDLE;
          stall_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-wait access is performed straight from the inputs; otherwise from the latched copy.
  assign acc_wen          = (state == IDLE) ? data_sram_wen   : lat_wen;
  assign acc_addr         = (state == IDLE) ? data_sram_addr  : lat_addr;
  assign acc_wdata        = (state == IDLE) ? data_sram_wdata : lat_wdata;
  assign acc_word         = acc_addr[ADDR_WIDTH+1:2];
  assign acc_in_range     = (acc_addr[31:ADDR_WIDTH+2] == '0);
  assign unused_addr_lsbs = ^acc_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      stallreq        <= 1'b0;
      data_sram_rdata <= 32'h0000_0000;
      addr_err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stallreq <= stall_nxt;
      if (perform) begin
        if (!acc_in_range) addr_err <= 1'b1;
        if (acc_wen == 4'b0000) data_sram_rdata <= acc_in_range ? mem[acc_word] : 32'h0000_0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_wen   <= data_sram_wen;
      lat_addr  <= data_sram_addr;
      lat_wdata <= data_sram_wdata;
    end
  end

  // Reset gates the commit so an abandoned write never lands; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && perform && acc_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i]) mem[acc_word][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: four instances with WAIT_CYCLES 0..3 share clk/rst;
// read expectations go onto a scoreboard queue at issue time and are popped at completion.
module tb_data_sram_responder;
  logic        clk;
  logic        rst;
  logic        en    [4];
  logic [3:0]  wen   [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        stall [4];
  logic        aerr  [4];

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_q [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(g)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en[g]),
      .data_sram_wen   (wen[g]),
      .data_sram_addr  (addr[g]),
      .data_sram_wdata (wdata[g]),
      .data_sram_rdata (rdata[g]),
      .stallreq        (stall[g]),
      .addr_err        (aerr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input int d);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, rdata[d], e);
  endtask

  // Called at a negedge; presents one request for one cycle and waits for it to complete.
  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp, input string tag);
    int k;
    en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    if (w == 4'b0000) exp_q.push_back(exp);
    @(negedge clk);
    en[d] = 1'b0;
    k = 0;
    while (stall[d] === 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 32'(k), 32'(d));
    if (w == 4'b0000) pop_check({tag, "_rdata"}, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; wen[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
      check($sformatf("reset_stall%0d", i), 32'(stall[i]), 32'h0);
      check($sformatf("reset_aerr%0d", i), 32'(aerr[i]), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Zero wait states: plain synchronous SRAM, one access per cycle.
    access(0, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, "w0_w10");
    access(0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, "w0_r10");
    access(0, 4'b1111, 32'h20, 32'h11223344, 32'h0, "w0_lane_all");
    access(0, 4'b0001, 32'h20, 32'h000000AA, 32'h0, "w0_lane0");
    access(0, 4'b1000, 32'h20, 32'hBB000000, 32'h0, "w0_lane3");
    check("w0_rdata_hold_after_writes", rdata[0], 32'hDEADBEEF);
    access(0, 4'b0000, 32'h20, 32'h0, 32'hBB2233AA, "w0_r20_merged");
    repeat (3) @(negedge clk);
    check("w0_rdata_hold_idle", rdata[0], 32'hBB2233AA);

    // Out of range: bits [31:12] nonzero with ADDR_WIDTH=10.
    check("oor_aerr_before", 32'(aerr[0]), 32'h0);
    access(0, 4'b0000, 32'h1000, 32'h0, 32'h0, "oor_read");
    check("oor_aerr_set", 32'(aerr[0]), 32'h1);
    access(0, 4'b1111, 32'h0, 32'h01020304, 32'h0, "oor_w0");
    access(0, 4'b1111, 32'h1000, 32'hFFFFFFFF, 32'h0, "oor_write");
    repeat (3) @(negedge clk);
    check("oor_aerr_sticky", 32'(aerr[0]), 32'h1);
    access(0, 4'b0000, 32'h0, 32'h0, 32'h01020304, "oor_mem_unchanged");

    // Two wait states; a different request held during the stall must not be consumed.
    access(2, 4'b1111, 32'h30, 32'h55AA55AA, 32'h0, "w2_w30");
    access(2, 4'b1111, 32'h34, 32'h0BADCAFE, 32'h0, "w2_w34");
    en[2] = 1'b1; wen[2] = 4'b0000; addr[2] = 32'h30;
    exp_q.push_back(32'h55AA55AA);
    @(negedge clk);
    check("w2_stall_t1", 32'(stall[2]), 32'h1);
    addr[2] = 32'h34;
    @(negedge clk);
    check("w2_stall_t2", 32'(stall[2]), 32'h1);
    check("w2_rdata_old_t2", rdata[2], 32'h0);
    @(negedge clk);
    check("w2_stall_t3", 32'(stall[2]), 32'h0);
    pop_check("w2_rdata_t3", 2);
    exp_q.push_back(32'h0BADCAFE);
    @(negedge clk);
    en[2] = 1'b0;
    check("w2_second_stall_t4", 32'(stall[2]), 32'h1);
    @(negedge clk);
    check("w2_second_stall_t5", 32'(stall[2]), 32'h1);
    @(negedge clk);
    check("w2_second_stall_t6", 32'(stall[2]), 32'h0);
    pop_check("w2_second_rdata_t6", 2);

    // One wait state: read-after-write issued as soon as the write completes.
    access(1, 4'b1111, 32'h80, 32'hCAFEF00D, 32'h0, "w1_w80");
    access(1, 4'b0000, 32'h80, 32'h0, 32'hCAFEF00D, "w1_raw80");

    // Three wait states: reset mid-write abandons it.
    access(3, 4'b1111, 32'h40, 32'h00001111, 32'h0, "w3_w40_prior");
    en[3] = 1'b1; wen[3] = 4'b1111; addr[3] = 32'h40; wdata[3] = 32'h12345678;
    @(negedge clk);
    en[3] = 1'b0;
    check("w3_stall_t1", 32'(stall[3]), 32'h1);
    @(negedge clk);
    check("w3_stall_t2", 32'(stall[3]), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("w3_stall_after_rst", 32'(stall[3]), 32'h0);
    check("rst_clears_aerr", 32'(aerr[0]), 32'h0);
    check("rst_clears_rdata", rdata[0], 32'h0);
    access(3, 4'b0000, 32'h40, 32'h0, 32'h00001111, "w3_r40_not_committed");
    access(0, 4'b0000, 32'h20, 32'h0, 32'hBB2233AA, "mem_survives_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
